// File: rtl/fft_tw_addr_gen_pkg.sv
// Shared constants, FSM state type and the (stage, butterfly) -> index/twiddle rule.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package fft_tw_addr_gen_pkg;

  localparam int FFT_LOGN      = 8;
  localparam int FFT_N         = 1 << FFT_LOGN;
  localparam int FFT_STAGE_GAP = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [FFT_LOGN-1:0] addr_a;
    logic [FFT_LOGN-1:0] addr_b;
    logic [FFT_LOGN-2:0] k;
  } bf_idx_t;

  // Operand pair and twiddle index of butterfly b in stage s for the default length.
  function automatic bf_idx_t bf_index(input int unsigned s, input int unsigned b);
    bf_idx_t     r;
    int unsigned span;
    int unsigned low;
    int unsigned a;
    span     = 32'd1 << s;
    low      = b & (span - 32'd1);
    a        = ((b >> s) << (s + 32'd1)) | low;
    r.addr_a = FFT_LOGN'(a);
    r.addr_b = FFT_LOGN'(a + span);
    r.k      = (FFT_LOGN-1)'(low * (FFT_N >> (s + 32'd1)));
    return r;
  endfunction

endpackage

// File: rtl/fft_tw_addr_gen_if.sv
// Start/ROM/butterfly bus of the twiddle address sequencer.
// Latency: n/a (wires only).
// Backpressure: bf_ready from the butterfly unit stalls the presented butterfly.
interface fft_tw_addr_gen_if
  import fft_tw_addr_gen_pkg::*;
#(
  parameter int LOGN     = FFT_LOGN,
  parameter int ADDRSIZE = FFT_LOGN
);

  localparam int STAGE_W = $clog2(LOGN);

  logic                start;
  logic                bf_ready;
  logic                rom_cs;
  logic [ADDRSIZE-1:0] rom_addr;
  logic                bf_valid;
  logic [LOGN-1:0]     addr_a;
  logic [LOGN-1:0]     addr_b;
  logic [STAGE_W-1:0]  stage;
  logic                busy;
  logic                done;

  // Sequencer side.
  modport master (
    input  start, bf_ready,
    output rom_cs, rom_addr, bf_valid, addr_a, addr_b, stage, busy, done
  );

  // Controller / butterfly-unit side.
  modport slave (
    output start, bf_ready,
    input  rom_cs, rom_addr, bf_valid, addr_a, addr_b, stage, busy, done
  );

endinterface

// File: rtl/fft_tw_addr_gen_bf_index.sv
// Combinational operand-pair and twiddle-index calculator for one (stage, butterfly).
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller holds s/b steady while stalled.
module fft_tw_addr_gen_bf_index #(
  parameter int LOGN = 8
) (
  input  logic [$clog2(LOGN)-1:0] s,
  input  logic [LOGN-2:0]         b,
  output logic [LOGN-1:0]         addr_a,
  output logic [LOGN-1:0]         addr_b,
  output logic [LOGN-2:0]         k
);

  logic [LOGN-1:0] span;
  logic [LOGN-1:0] mask;
  logic [LOGN-1:0] bw;
  logic [LOGN-1:0] low;
  logic [LOGN-1:0] a;

  // Insert a zero at bit s of b for addr_a; the low s bits pick the twiddle.
  // The double left shift avoids s+1 wrapping in the narrow stage width.
  always_comb begin
    span   = LOGN'(1) << s;
    mask   = span - LOGN'(1);
    bw     = {1'b0, b};
    low    = bw & mask;
    a      = (((bw >> s) << s) << 1) | low;
    addr_a = a;
    addr_b = a + span;
    k      = low[LOGN-2:0] << (LOGN - 1 - s);
  end

endmodule

// File: rtl/fft_tw_addr_gen.sv
// Radix-2 DIT FFT address sequencer: twiddle ROM address plus aligned operand pair.
// Latency: start -> rom_addr 1 cycle, -> first bf_valid 2 cycles; one butterfly per accepted cycle.
// Backpressure: bf_valid & !bf_ready freezes counters, issue register and rom_addr.
module fft_tw_addr_gen
  import fft_tw_addr_gen_pkg::*;
#(
  parameter int LOGN      = FFT_LOGN,
  parameter int ADDRSIZE  = FFT_LOGN,
  parameter int STAGE_GAP = FFT_STAGE_GAP
) (
  input  logic              clk,
  input  logic              rst,
  fft_tw_addr_gen_if.master bus
);

  localparam int STAGE_W = $clog2(LOGN);
  localparam int HALF_W  = LOGN - 1;
  localparam int GAP_W   = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

  state_t             state;
  state_t             state_nxt;
  logic [STAGE_W-1:0] s_cnt;
  logic [HALF_W-1:0]  b_cnt;
  logic [GAP_W-1:0]   gap_cnt;

  logic               advance;
  logic               issue_now;
  logic               last_b;
  logic               last_s;

  logic [LOGN-1:0]    idx_a;
  logic [LOGN-1:0]    idx_b;
  logic [HALF_W-1:0]  idx_k;

  // Issue stage: address sent to the ROM this cycle, operands waiting for its data.
  logic                iss_vld;
  logic [ADDRSIZE-1:0] iss_k;
  logic [LOGN-1:0]     iss_a;
  logic [LOGN-1:0]     iss_b;
  logic [STAGE_W-1:0]  iss_s;

  // Present stage: lines up with the ROM's registered twiddle output.
  logic                pre_vld;
  logic [LOGN-1:0]     pre_a;
  logic [LOGN-1:0]     pre_b;
  logic [STAGE_W-1:0]  pre_s;

  fft_tw_addr_gen_bf_index #(.LOGN(LOGN)) u_bf_index (
    .s      (s_cnt),
    .b      (b_cnt),
    .addr_a (idx_a),
    .addr_b (idx_b),
    .k      (idx_k)
  );

  assign advance = !pre_vld || bus.bf_ready;
  assign last_b  = &b_cnt;
  assign last_s  = (s_cnt == STAGE_W'(LOGN - 1));

  // Next state and issue decision; stage 0 butterfly 0 issues in the start cycle.
  always_comb begin
    state_nxt = state;
    issue_now = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && advance) begin
          issue_now = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (advance) begin
          issue_now = 1'b1;
          if (last_b) state_nxt = GAP;
        end
      end
      GAP: begin
        // After the final stage GAP only drains the pipe until the last butterfly is taken.
        if (last_s) begin
          if (!iss_vld && advance) state_nxt = DONE;
        end else if (gap_cnt == GAP_W'(STAGE_GAP - 1)) begin
          state_nxt = RUN;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, stage/butterfly counters and inter-stage gap timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      s_cnt   <= '0;
      b_cnt   <= '0;
      gap_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (issue_now) b_cnt <= last_b ? '0 : b_cnt + HALF_W'(1);
      if (state == GAP && state_nxt == RUN) s_cnt <= s_cnt + STAGE_W'(1);
      else if (state == DONE)               s_cnt <= '0;
      gap_cnt <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;
    end
  end

  // Two-stage issue/present pipeline; everything holds when the butterfly stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_vld <= 1'b0;
      iss_k   <= '0;
      iss_a   <= '0;
      iss_b   <= '0;
      iss_s   <= '0;
      pre_vld <= 1'b0;
      pre_a   <= '0;
      pre_b   <= '0;
      pre_s   <= '0;
    end else if (advance) begin
      pre_vld <= iss_vld;
      if (iss_vld) begin
        pre_a <= iss_a;
        pre_b <= iss_b;
        pre_s <= iss_s;
      end
      iss_vld <= issue_now;
      if (issue_now) begin
        iss_k <= ADDRSIZE'(idx_k);
        iss_a <= idx_a;
        iss_b <= idx_b;
        iss_s <= s_cnt;
      end
    end
  end

  assign bus.rom_cs   = (state == RUN) || pre_vld;
  assign bus.rom_addr = iss_k;
  assign bus.bf_valid = pre_vld;
  assign bus.addr_a   = pre_a;
  assign bus.addr_b   = pre_b;
  assign bus.stage    = pre_s;
  assign bus.busy     = (state == RUN) || (state == GAP);
  assign bus.done     = (state == DONE);

endmodule
